// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for the interrupt/exception sequencer.
//   - cause indices into the 23-bit cause vector
//   - sequencer state encoding
//   - default set of causes whose instruction is repeated after service
package intc_pkg;

    localparam int N_CAUSE = 23;
    localparam int N_INT   = 6;

    localparam int CA_RESET    = 0;
    localparam int CA_ILL      = 1;
    localparam int CA_MAL      = 2;
    localparam int CA_PF_FETCH = 3;
    localparam int CA_PF_LDST  = 4;
    localparam int CA_TRAP     = 5;
    localparam int CA_OVF      = 6;
    localparam int CA_EXT0     = 7;

    // Page faults re-execute the faulting instruction after the handler.
    localparam logic [N_CAUSE-1:0] RPT_MASK_DEF = 23'h000018;

    // state   | meaning
    // BOOT    | after reset; forces the reset "interrupt" on the next edge
    // RUN     | normal execution, all enabled causes accepted
    // JISR    | one-cycle jump to the handler, spr captures state
    // ISR     | inside the handler, only non-maskable causes accepted
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_JISR = 2'd2,
        ST_ISR  = 2'd3
    } intc_state_e;

endpackage

// File: rtl/interrupt_ctrl_prio_enc23.sv
// prio_enc23: combinational lowest-set-bit encoder over the 23-bit
// cause vector. Lowest index has the highest priority.
//   vec_i  in  23  cause vector
//   idx_o  out 5   index of the lowest set bit (0 when vec_i is 0)
module prio_enc23 (
    input  logic [22:0] vec_i,
    output logic [4:0]  idx_o
);

    // Scan from the top so the lowest set bit is the last to write.
    always_comb begin
        idx_o = 5'd0;
        for (int i = 22; i >= 0; i--) begin
            if (vec_i[i]) idx_o = 5'(i);
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: interrupt/exception sequencer in front of spr.
// Collects internal causes of the retiring instruction and external
// interrupt lines, applies the SR mask, and issues jisr/mca/rpt/il so
// spr captures state. Tracks handler residency until eret retires.
//
// Optional feature macro: INTC_EXT_LATCH_EN
//   defined   : ext_pending is sticky per line, set on a rising edge of
//               ev_ext_i, cleared when jisr fires with that cause set
//               (set wins over clear)
//   undefined : ext_pending follows ev_ext_i (level-sensitive)
//
// Ports
//   clk_i          in   1      clock, rising edge
//   reset_i        in   1      asynchronous, active-high reset
//   ev_int_i       in   6      internal causes 1..6 of the retiring instr
//   ev_ext_i       in   N_EXT  external interrupt request lines
//   sr_i           in   32     SR; bit j masks cause j for j >= 6
//   retire_i       in   1      an instruction completes this cycle
//   eret_i         in   1      the retiring instruction is eret
//   jisr_o         out  1      one-cycle jump-to-ISR pulse
//   mca_o          out  23     registered masked cause vector
//   rpt_o          out  1      registered repeat flag
//   il_o           out  5      registered index of lowest mca bit
//   in_isr_o       out  1      core is inside the service routine
//   ext_pending_o  out  N_EXT  current external pending vector
module interrupt_ctrl
    import intc_pkg::*;
#(
    parameter int                  N_EXT    = 16,
    parameter logic [N_CAUSE-1:0]  RPT_MASK = RPT_MASK_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_INT-1:0]    ev_int_i,
    input  logic [N_EXT-1:0]    ev_ext_i,
    input  logic [31:0]         sr_i,
    input  logic                retire_i,
    input  logic                eret_i,
    output logic                jisr_o,
    output logic [N_CAUSE-1:0]  mca_o,
    output logic                rpt_o,
    output logic [4:0]          il_o,
    output logic                in_isr_o,
    output logic [N_EXT-1:0]    ext_pending_o
);

    intc_state_e         state_q, state_d;
    logic [N_CAUSE-1:0]  mca_q, mca_d;
    logic [4:0]          il_q, il_d;
    logic                rpt_q, rpt_d;

    logic [N_CAUSE-1:0]  ca_c;
    logic [N_CAUSE-1:0]  mask_c;
    logic [N_CAUSE-1:0]  mca_c;
    logic [4:0]          il_c;

    // Only SR bits that gate causes are consumed.
    logic unused_sr;
    assign unused_sr = ^{sr_i[31:N_CAUSE], sr_i[CA_OVF-1:0]};

    assign ca_c = {ext_pending_o, ev_int_i, 1'b0};

    // Causes 1..5 are never masked; maskable causes are all blocked
    // while the handler runs so it cannot be re-entered by them.
    always_comb begin
        mask_c                   = '0;
        mask_c[CA_TRAP:CA_ILL]   = '1;
        if (state_q != ST_ISR) begin
            mask_c[N_CAUSE-1:CA_OVF] = sr_i[N_CAUSE-1:CA_OVF];
        end
    end

    assign mca_c = ca_c & mask_c;

    prio_enc23 u_prio (
        .vec_i (mca_c),
        .idx_o (il_c)
    );

    always_comb begin
        state_d = state_q;
        mca_d   = mca_q;
        il_d    = il_q;
        rpt_d   = rpt_q;
        case (state_q)
            ST_BOOT: begin
                state_d          = ST_JISR;
                mca_d            = '0;
                mca_d[CA_RESET]  = 1'b1;
                il_d             = 5'(CA_RESET);
                rpt_d            = 1'b0;
            end
            ST_RUN, ST_ISR: begin
                // A cause beats a simultaneous eret.
                if (retire_i && (|mca_c)) begin
                    state_d = ST_JISR;
                    mca_d   = mca_c;
                    il_d    = il_c;
                    rpt_d   = |(mca_c & RPT_MASK);
                end else if ((state_q == ST_ISR) && retire_i && eret_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_JISR: begin
                // Pipeline is flushing; retire is ignored here.
                state_d = ST_ISR;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_BOOT;
            mca_q   <= '0;
            il_q    <= '0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mca_q   <= mca_d;
            il_q    <= il_d;
            rpt_q   <= rpt_d;
        end
    end

    assign jisr_o   = (state_q == ST_JISR);
    assign in_isr_o = (state_q == ST_JISR) || (state_q == ST_ISR);
    assign mca_o    = mca_q;
    assign il_o     = il_q;
    assign rpt_o    = rpt_q;

`ifdef INTC_EXT_LATCH_EN
    logic [N_EXT-1:0] ev_ext_q;
    logic [N_EXT-1:0] pend_q, pend_d;
    logic [N_EXT-1:0] clr_c;

    always_comb begin
        clr_c  = jisr_o ? mca_q[N_CAUSE-1:CA_EXT0] : '0;
        pend_d = (pend_q & ~clr_c) | (ev_ext_i & ~ev_ext_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ev_ext_q <= '0;
            pend_q   <= '0;
        end else begin
            ev_ext_q <= ev_ext_i;
            pend_q   <= pend_d;
        end
    end

    assign ext_pending_o = pend_q;
`else
    assign ext_pending_o = ev_ext_i;
`endif

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

    typedef struct packed {
        logic [22:0] mca;
        logic [4:0]  il;
        logic        rpt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  ev_int;
    logic [15:0] ev_ext;
    logic [31:0] sr;
    logic        retire;
    logic        eret;
    logic        jisr;
    logic [22:0] mca;
    logic        rpt;
    logic [4:0]  il;
    logic        in_isr;
    logic [15:0] ext_pending;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    interrupt_ctrl dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .ev_int_i      (ev_int),
        .ev_ext_i      (ev_ext),
        .sr_i          (sr),
        .retire_i      (retire),
        .eret_i        (eret),
        .jisr_o        (jisr),
        .mca_o         (mca),
        .rpt_o         (rpt),
        .il_o          (il),
        .in_isr_o      (in_isr),
        .ext_pending_o (ext_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Leave the handler with a plain eret and confirm in_isr drops.
    task automatic leave_isr(input string name);
        retire = 1'b1; eret = 1'b1; ev_int = '0;
        cycle();
        retire = 1'b0; eret = 1'b0;
        n_cmp++;
        if (in_isr !== 1'b0 || jisr !== 1'b0) begin
            n_err++;
            $display("FAIL %s_eret: in_isr=%0b jisr=%0b want 0/0", name, in_isr, jisr);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; ev_int = '0; ev_ext = '0; sr = '0; retire = 1'b0; eret = 1'b0;
        #2;
        n_cmp++;
        if ({jisr, mca, rpt, il, in_isr, ext_pending} !== '0) begin
            n_err++;
            $display("FAIL reset_outs: jisr=%0b mca=%h rpt=%0b il=%0d in_isr=%0b pend=%h want all 0",
                     jisr, mca, rpt, il, in_isr, ext_pending);
        end
        cycle(); cycle();
        reset = 1'b0;
        sb.push_back('{mca: 23'h1, il: 5'd0, rpt: 1'b0});
        cycle();
        n_cmp++;
        if (jisr !== 1'b1 || in_isr !== 1'b1) begin
            n_err++;
            $display("FAIL boot_jisr: jisr=%0b in_isr=%0b want 1/1", jisr, in_isr);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({mca, il, rpt} !== e) begin
                n_err++;
                $display("FAIL boot_fields: mca=%h il=%0d rpt=%0b want mca=%h il=%0d rpt=%0b",
                         mca, il, rpt, e.mca, e.il, e.rpt);
            end
        end
        cycle();
        n_cmp++;
        if (jisr !== 1'b0 || in_isr !== 1'b1) begin
            n_err++;
            $display("FAIL boot_isr: jisr=%0b in_isr=%0b want 0/1", jisr, in_isr);
        end
        leave_isr("boot");
    endtask

    task automatic test_pf_fetch();
        exp_t e;
        retire = 1'b1; ev_int = 6'b000100; sr = '0;
        sb.push_back('{mca: 23'h8, il: 5'd3, rpt: 1'b1});
        cycle();
        retire = 1'b0; ev_int = '0;
        n_cmp++;
        if (jisr !== 1'b1 || in_isr !== 1'b1) begin
            n_err++;
            $display("FAIL pf_jisr: jisr=%0b in_isr=%0b want 1/1", jisr, in_isr);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({mca, il, rpt} !== e) begin
                n_err++;
                $display("FAIL pf_fields: mca=%h il=%0d rpt=%0b want mca=%h il=%0d rpt=%0b",
                         mca, il, rpt, e.mca, e.il, e.rpt);
            end
        end
        cycle();
        n_cmp++;
        if (jisr !== 1'b0 || mca !== 23'h8) begin
            n_err++;
            $display("FAIL pf_pulse: jisr=%0b mca=%h want 0 and stable 000008", jisr, mca);
        end
        leave_isr("pf");
    endtask

    task automatic test_ext_mask();
        exp_t e;
        sr = '0; ev_ext = 16'h0001;
        cycle();
        retire = 1'b1;
        cycle();
        retire = 1'b0;
        n_cmp++;
        if (jisr !== 1'b0 || in_isr !== 1'b0 || ext_pending !== 16'h0001) begin
            n_err++;
            $display("FAIL ext_masked: jisr=%0b in_isr=%0b pend=%h want 0/0/0001", jisr, in_isr, ext_pending);
        end
        sr = 32'h80; retire = 1'b1;
        sb.push_back('{mca: 23'h80, il: 5'd7, rpt: 1'b0});
        cycle();
        retire = 1'b0;
        n_cmp++;
        if (jisr !== 1'b1) begin
            n_err++;
            $display("FAIL ext_jisr: jisr=%0b want 1", jisr);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({mca, il, rpt} !== e) begin
                n_err++;
                $display("FAIL ext_fields: mca=%h il=%0d rpt=%0b want mca=%h il=%0d rpt=%0b",
                         mca, il, rpt, e.mca, e.il, e.rpt);
            end
        end
        cycle();
        // Still requesting, but maskable causes are blocked inside the handler.
        retire = 1'b1;
        cycle();
        retire = 1'b0;
        n_cmp++;
        if (jisr !== 1'b0 || in_isr !== 1'b1) begin
            n_err++;
            $display("FAIL ext_isr_masked: jisr=%0b in_isr=%0b want 0/1", jisr, in_isr);
        end
        ev_ext = '0; sr = '0;
        leave_isr("ext");
    endtask

    task automatic test_eret_cause();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            retire = 1'b1; ev_int = 6'b010000;
            sb.push_back('{mca: 23'h20, il: 5'd5, rpt: 1'b0});
            cycle();
            retire = 1'b0; ev_int = '0;
            n_cmp++;
            if (jisr !== 1'b1) begin
                n_err++;
                $display("FAIL trap_jisr%0d: jisr=%0b want 1", k, jisr);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({mca, il, rpt} !== e) begin
                    n_err++;
                    $display("FAIL trap_fields%0d: mca=%h il=%0d rpt=%0b want mca=%h il=%0d rpt=%0b",
                             k, mca, il, rpt, e.mca, e.il, e.rpt);
                end
            end
            cycle();
            retire = 1'b1; eret = 1'b1; sr = 32'h40;
            if (k == 0) begin
                ev_int = 6'b100000;
                cycle();
                retire = 1'b0; eret = 1'b0; ev_int = '0; sr = '0;
                n_cmp++;
                if (jisr !== 1'b0 || in_isr !== 1'b0) begin
                    n_err++;
                    $display("FAIL eret_ovf: jisr=%0b in_isr=%0b want 0/0", jisr, in_isr);
                end
            end else begin
                ev_int = 6'b000010;
                sb.push_back('{mca: 23'h4, il: 5'd2, rpt: 1'b0});
                cycle();
                retire = 1'b0; eret = 1'b0; ev_int = '0; sr = '0;
                n_cmp++;
                if (jisr !== 1'b1 || in_isr !== 1'b1) begin
                    n_err++;
                    $display("FAIL eret_mal_jisr: jisr=%0b in_isr=%0b want 1/1", jisr, in_isr);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if ({mca, il, rpt} !== e) begin
                        n_err++;
                        $display("FAIL eret_mal_fields: mca=%h il=%0d rpt=%0b want mca=%h il=%0d rpt=%0b",
                                 mca, il, rpt, e.mca, e.il, e.rpt);
                    end
                end
                cycle();
                leave_isr("mal");
            end
        end
    endtask

    typedef struct {
        logic [5:0]  ev_int;
        logic [15:0] ev_ext;
        logic [31:0] sr;
        logic [22:0] mca;
        logic [4:0]  il;
        logic        rpt;
    } vec_t;

    task automatic test_priority();
        vec_t v[6];
        exp_t e;
        v[0] = '{6'b001000, 16'h0000, 32'h0000_0000, 23'h000010, 5'd4,  1'b1};
        v[1] = '{6'b110010, 16'h0000, 32'h0000_0040, 23'h000064, 5'd2,  1'b0};
        v[2] = '{6'b100000, 16'h0000, 32'h0000_0000, 23'h000000, 5'd0,  1'b0};
        v[3] = '{6'b000000, 16'h8000, 32'h0040_0000, 23'h400000, 5'd22, 1'b0};
        v[4] = '{6'b011000, 16'h0000, 32'h0000_0000, 23'h000030, 5'd4,  1'b1};
        v[5] = '{6'b000001, 16'h0004, 32'h0000_0200, 23'h000202, 5'd1,  1'b0};
        foreach (v[i]) begin
            ev_ext = v[i].ev_ext; sr = v[i].sr;
            cycle();
            retire = 1'b1; ev_int = v[i].ev_int;
            if (v[i].mca != '0) sb.push_back('{mca: v[i].mca, il: v[i].il, rpt: v[i].rpt});
            cycle();
            retire = 1'b0; ev_int = '0; ev_ext = '0; sr = '0;
            n_cmp++;
            if (jisr !== (v[i].mca != '0)) begin
                n_err++;
                $display("FAIL prio%0d_jisr: jisr=%0b want %0b", i, jisr, (v[i].mca != '0));
            end
            if (jisr === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({mca, il, rpt} !== e) begin
                    n_err++;
                    $display("FAIL prio%0d_fields: mca=%h il=%0d rpt=%0b want mca=%h il=%0d rpt=%0b",
                             i, mca, il, rpt, e.mca, e.il, e.rpt);
                end
            end
            if (v[i].mca != '0) begin
                cycle();
                leave_isr("prio");
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        retire = 1'b1; ev_int = 6'b010000;
        sb.push_back('{mca: 23'h20, il: 5'd5, rpt: 1'b0});
        cycle();
        ev_int = 6'b000001;
        n_cmp++;
        if (jisr !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first: jisr=%0b want 1", jisr);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({mca, il, rpt} !== e) begin
                n_err++;
                $display("FAIL b2b_first_fields: mca=%h il=%0d want mca=%h il=%0d", mca, il, e.mca, e.il);
            end
        end
        cycle();
        retire = 1'b0; ev_int = '0;
        n_cmp++;
        if (jisr !== 1'b0 || in_isr !== 1'b1 || mca !== 23'h20) begin
            n_err++;
            $display("FAIL b2b_ignore: jisr=%0b in_isr=%0b mca=%h want 0/1/000020", jisr, in_isr, mca);
        end
        retire = 1'b1; ev_int = 6'b000001;
        sb.push_back('{mca: 23'h2, il: 5'd1, rpt: 1'b0});
        cycle();
        retire = 1'b0; ev_int = '0;
        n_cmp++;
        if (jisr !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_nested: jisr=%0b want 1", jisr);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({mca, il, rpt} !== e) begin
                n_err++;
                $display("FAIL b2b_nested_fields: mca=%h il=%0d want mca=%h il=%0d", mca, il, e.mca, e.il);
            end
        end
        cycle();
        leave_isr("b2b");
    endtask

`ifdef INTC_EXT_LATCH_EN
    task automatic test_ext_latch();
        exp_t e;
        ev_ext = 16'h0008;
        cycle();
        ev_ext = '0;
        cycle();
        n_cmp++;
        if (ext_pending !== 16'h0008) begin
            n_err++;
            $display("FAIL latch_sticky: pend=%h want 0008", ext_pending);
        end
        sr = 32'h400; retire = 1'b1;
        sb.push_back('{mca: 23'h400, il: 5'd10, rpt: 1'b0});
        cycle();
        retire = 1'b0; sr = '0;
        n_cmp++;
        if (jisr !== 1'b1) begin
            n_err++;
            $display("FAIL latch_jisr: jisr=%0b want 1", jisr);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({mca, il, rpt} !== e) begin
                n_err++;
                $display("FAIL latch_fields: mca=%h il=%0d want mca=%h il=%0d", mca, il, e.mca, e.il);
            end
        end
        cycle();
        n_cmp++;
        if (ext_pending !== 16'h0000) begin
            n_err++;
            $display("FAIL latch_clear: pend=%h want 0000", ext_pending);
        end
        leave_isr("latch");
    endtask
`endif

    task automatic test_reset_mid();
        exp_t e;
        retire = 1'b1; ev_int = 6'b010000;
        sb.push_back('{mca: 23'h20, il: 5'd5, rpt: 1'b0});
        cycle();
        retire = 1'b0; ev_int = '0;
        n_cmp++;
        if (jisr !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_jisr: jisr=%0b want 1", jisr);
        end
        if (sb.size() > 0) e = sb.pop_front();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({jisr, mca, rpt, il, in_isr} !== '0) begin
            n_err++;
            $display("FAIL rmid_clear: jisr=%0b mca=%h rpt=%0b il=%0d in_isr=%0b want all 0",
                     jisr, mca, rpt, il, in_isr);
        end
        cycle();
        reset = 1'b0;
        sb.push_back('{mca: 23'h1, il: 5'd0, rpt: 1'b0});
        cycle();
        n_cmp++;
        if (jisr !== 1'b1 || in_isr !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_boot: jisr=%0b in_isr=%0b want 1/1", jisr, in_isr);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({mca, il, rpt} !== e) begin
                n_err++;
                $display("FAIL rmid_boot_fields: mca=%h il=%0d rpt=%0b want mca=%h il=%0d rpt=%0b",
                         mca, il, rpt, e.mca, e.il, e.rpt);
            end
        end
        cycle();
        leave_isr("rmid");
    endtask

    initial begin
        test_reset();
        test_pf_fetch();
        test_ext_mask();
        test_eret_cause();
        test_priority();
        test_back_to_back();
`ifdef INTC_EXT_LATCH_EN
        test_ext_latch();
`endif
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
